// File: rtl/csr_counter_read_arbiter.sv
// Arbitrates the counter CSR read port between CPU half-word reads and atomic 64-bit debug reads.
// Debug reads use HI-LO-HI with bounded retry so a carry between halves is never returned torn.
//   state   | meaning
//   IDLE    | arbitrate, accept one request
//   CPU_ISS | CPU read strobe on the counter port
//   CPU_CAP | capture CPU data, respond next cycle
//   DBG_HI0 | debug: first HI read issued
//   DBG_LO  | debug: LO read issued (first pass captures H0)
//   DBG_HI1 | debug: check HI read issued, LO captured
//   DBG_CHK | compare H1 with H0: respond, retry, or respond with error
module csr_counter_read_arbiter #(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic [1:0]  cpu_req_sel,
  output logic        cpu_req_ready,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_data,
  input  logic        dbg_req_valid,
  input  logic        dbg_req_cnt,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output logic [63:0] dbg_rsp_data,
  output logic        dbg_rsp_err,
  output logic        csr_rd_en,
  output logic [1:0]  csr_rd_sel,
  input  logic [31:0] csr_rd_data
);

  typedef enum logic [2:0] {
    IDLE, CPU_ISS, CPU_CAP, DBG_HI0, DBG_LO, DBG_HI1, DBG_CHK
  } state_t;

  state_t      state;
  logic        last_grant_dbg;
  logic        dbg_cnt;
  logic [3:0]  retry_cnt;
  logic [31:0] hi0;
  logic [31:0] lo;

  // Tie goes to whoever was not granted last.
  assign cpu_req_ready = !rst && (state == IDLE) && cpu_req_valid &&
                         (!dbg_req_valid || last_grant_dbg);
  assign dbg_req_ready = !rst && (state == IDLE) && dbg_req_valid &&
                         (!cpu_req_valid || !last_grant_dbg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant_dbg <= 1'b1;
      dbg_cnt        <= 1'b0;
      retry_cnt      <= 4'd0;
      hi0            <= 32'd0;
      lo             <= 32'd0;
      cpu_rsp_valid  <= 1'b0;
      cpu_rsp_data   <= 32'd0;
      dbg_rsp_valid  <= 1'b0;
      dbg_rsp_data   <= 64'd0;
      dbg_rsp_err    <= 1'b0;
      csr_rd_en      <= 1'b0;
      csr_rd_sel     <= 2'b00;
    end else begin
      cpu_rsp_valid <= 1'b0;
      dbg_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_ready) begin
            state          <= CPU_ISS;
            csr_rd_en      <= 1'b1;
            csr_rd_sel     <= cpu_req_sel;
            last_grant_dbg <= 1'b0;
          end else if (dbg_req_ready) begin
            state          <= DBG_HI0;
            csr_rd_en      <= 1'b1;
            csr_rd_sel     <= {1'b1, dbg_req_cnt};
            dbg_cnt        <= dbg_req_cnt;
            retry_cnt      <= 4'd0;
            last_grant_dbg <= 1'b1;
          end
        end
        CPU_ISS: begin
          csr_rd_en <= 1'b0;
          state     <= CPU_CAP;
        end
        CPU_CAP: begin
          cpu_rsp_valid <= 1'b1;
          cpu_rsp_data  <= csr_rd_data;
          state         <= IDLE;
        end
        DBG_HI0: begin
          csr_rd_sel <= {1'b0, dbg_cnt};
          state      <= DBG_LO;
        end
        DBG_LO: begin
          // On retries H0 was already loaded from the mismatching H1.
          if (retry_cnt == 4'd0) hi0 <= csr_rd_data;
          csr_rd_sel <= {1'b1, dbg_cnt};
          state      <= DBG_HI1;
        end
        DBG_HI1: begin
          lo        <= csr_rd_data;
          csr_rd_en <= 1'b0;
          state     <= DBG_CHK;
        end
        DBG_CHK: begin
          if (csr_rd_data == hi0) begin
            dbg_rsp_valid <= 1'b1;
            dbg_rsp_data  <= {hi0, lo};
            dbg_rsp_err   <= 1'b0;
            state         <= IDLE;
          end else if (retry_cnt < 4'(MAX_RETRY)) begin
            hi0        <= csr_rd_data;
            retry_cnt  <= retry_cnt + 4'd1;
            csr_rd_en  <= 1'b1;
            csr_rd_sel <= {1'b0, dbg_cnt};
            state      <= DBG_LO;
          end else begin
            dbg_rsp_valid <= 1'b1;
            dbg_rsp_data  <= {csr_rd_data, lo};
            dbg_rsp_err   <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_counter_read_arbiter.sv
// Scoreboard bench for csr_counter_read_arbiter: counter values are a linear function of clock edge,
// so expected responses and their arrival cycles are predicted when each request is accepted.
module tb_csr_counter_read_arbiter;

  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic [1:0]  cpu_req_sel = 2'b00;
  logic        cpu_req_ready;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic        dbg_req_valid = 1'b0;
  logic        dbg_req_cnt = 1'b0;
  logic        dbg_req_ready;
  logic        dbg_rsp_valid;
  logic [63:0] dbg_rsp_data;
  logic        dbg_rsp_err;
  logic        csr_rd_en;
  logic [1:0]  csr_rd_sel;
  logic [31:0] csr_rd_data = 32'd0;

  csr_counter_read_arbiter #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_sel(cpu_req_sel), .cpu_req_ready(cpu_req_ready),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .dbg_req_valid(dbg_req_valid), .dbg_req_cnt(dbg_req_cnt), .dbg_req_ready(dbg_req_ready),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .csr_rd_en(csr_rd_en), .csr_rd_sel(csr_rd_sel), .csr_rd_data(csr_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dbg_q[$];
  logic [63:0] base[2];
  logic [63:0] step_v[2];
  int          ecount = 0;
  int          free_at = 0;
  logic        m_last_dbg = 1'b1;
  int          tests = 0;
  int          fails = 0;

  // Counter value seen by a read sampled at clock edge e.
  function automatic logic [31:0] cnt_half(input logic [1:0] sel, input int e);
    logic [63:0] v;
    v = base[sel[0]] + step_v[sel[0]] * 64'(e);
    return sel[1] ? v[63:32] : v[31:0];
  endfunction

  // Counter block: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    ecount <= ecount + 1;
    if (csr_rd_en) csr_rd_data <= cnt_half(csr_rd_sel, ecount);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Reads at edges: HI n+1, then (LO, HI) pairs every 3 edges until HI agrees or retries run out.
  task automatic dbg_model(input logic c, input int n, output exp_t e, output int r);
    logic [31:0] h0, h1, l;
    h0 = cnt_half({1'b1, c}, n + 1);
    l  = cnt_half({1'b0, c}, n + 2);
    h1 = cnt_half({1'b1, c}, n + 3);
    r  = 0;
    while (h1 != h0 && r < MAX_RETRY) begin
      r++;
      h0 = h1;
      l  = cnt_half({1'b0, c}, n + 2 + 3 * r);
      h1 = cnt_half({1'b1, c}, n + 3 + 3 * r);
    end
    e.data = {h1, l};
    e.err  = (h1 != h0);
    e.cyc  = n + 5 + 3 * r;
  endtask

  task automatic step(input logic cv, input logic [1:0] cs, input logic dv, input logic dc);
    int   n, r;
    logic idle, exp_c, exp_d;
    exp_t e;
    @(negedge clk);
    cpu_req_valid = cv;
    cpu_req_sel   = cs;
    dbg_req_valid = dv;
    dbg_req_cnt   = dc;
    #1;
    n     = ecount;
    idle  = (n >= free_at);
    exp_c = idle && cv && (!dv || m_last_dbg);
    exp_d = idle && dv && !exp_c;
    chk("cpu_req_ready", 64'(cpu_req_ready), 64'(exp_c));
    chk("dbg_req_ready", 64'(dbg_req_ready), 64'(exp_d));
    if (exp_c) begin
      e.data = {32'd0, cnt_half(cs, n + 1)};
      e.err  = 1'b0;
      e.cyc  = n + 3;
      cpu_q.push_back(e);
      m_last_dbg = 1'b0;
      free_at    = n + 3;
    end
    if (exp_d) begin
      dbg_model(dc, n, e, r);
      dbg_q.push_back(e);
      m_last_dbg = 1'b1;
      free_at    = e.cyc;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (ecount < free_at || cpu_q.size() != 0 || dbg_q.size() != 0); i++)
      step(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_rsp_valid) begin
        if (cpu_q.size() == 0) chk("cpu_rsp_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = cpu_q.pop_front();
          chk("cpu_rsp_data", 64'(cpu_rsp_data), e.data);
          chk("cpu_rsp_cycle", 64'(ecount), 64'(e.cyc));
        end
      end
      if (dbg_rsp_valid) begin
        if (dbg_q.size() == 0) chk("dbg_rsp_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = dbg_q.pop_front();
          chk("dbg_rsp_data", dbg_rsp_data, e.data);
          chk("dbg_rsp_err", 64'(dbg_rsp_err), 64'(e.err));
          chk("dbg_rsp_cycle", 64'(ecount), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    base[0] = 64'd0; base[1] = 64'd0; step_v[0] = 64'd0; step_v[1] = 64'd0;
    repeat (3) @(negedge clk);
    cpu_req_valid = 1'b1; dbg_req_valid = 1'b1;
    #1;
    chk("rst_cpu_ready", 64'(cpu_req_ready), 64'd0);
    chk("rst_dbg_ready", 64'(dbg_req_ready), 64'd0);
    chk("rst_rd_en", 64'(csr_rd_en), 64'd0);
    chk("rst_rd_sel", 64'(csr_rd_sel), 64'd0);
    chk("rst_rsp_valid", 64'({cpu_rsp_valid, dbg_rsp_valid, dbg_rsp_err}), 64'd0);
    chk("rst_rsp_data", dbg_rsp_data | 64'(cpu_rsp_data), 64'd0);
    cpu_req_valid = 1'b0; dbg_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Continuous contention from reset: CPU first, then strict alternation.
    base[0] = 64'h0000_0003_1234_0000; step_v[0] = 64'd1;
    base[1] = 64'h0000_0000_0000_0100; step_v[1] = 64'd0;
    for (int i = 0; i < 30; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 2'b00, 1'b0, 1'b0);
    drain();

    // CPU upper cycle half; strobe must appear the cycle after the handshake.
    base[0] = 64'h0000_0005_0000_0010; step_v[0] = 64'd0;
    step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("cpu_iss_rd_en", 64'(csr_rd_en), 64'd1);
    chk("cpu_iss_rd_sel", 64'(csr_rd_sel), 64'd2);
    drain();

    // Stable instret: HI, LO, HI issues then no strobe in the compare cycle.
    base[1] = 64'h0000_0001_2345_6789; step_v[1] = 64'd0;
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_sel;
      exp_sel = (i == 1) ? 2'b01 : 2'b11;
      step(1'b0, 2'b00, 1'b0, 1'b0);
      chk("dbg_rd_en", 64'(csr_rd_en), (i < 3) ? 64'd1 : 64'd0);
      if (i < 3) chk("dbg_rd_sel", 64'(csr_rd_sel), 64'(exp_sel));
    end
    drain();

    // LO wraps between the two HI reads: one retry, clean result.
    step_v[1] = 64'd1;
    base[1]   = 64'h0000_0000_FFFF_FFFE - 64'(ecount + 2);
    step(1'b0, 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    drain();

    // HI changes on every read: retries exhausted, error response.
    step_v[1] = 64'h0000_0001_0000_0000;
    step(1'b0, 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    drain();

    // Reset while the check HI read is on the port: abort with no response.
    step_v[1] = 64'd0; base[1] = 64'h0000_00AA_0000_00BB;
    step(1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_rd_en", 64'(csr_rd_en), 64'd0);
    chk("abort_rsp_valid", 64'({cpu_rsp_valid, dbg_rsp_valid, dbg_rsp_err}), 64'd0);
    chk("abort_rsp_data", dbg_rsp_data | 64'(cpu_rsp_data), 64'd0);
    if (dbg_q.size() != 0) void'(dbg_q.pop_back());
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    m_last_dbg = 1'b1;
    free_at    = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b0, 1'b0);

    step(1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    drain();

    // Random traffic across counter wraps.
    base[0] = 64'h0000_0007_FFFF_FF00; step_v[0] = 64'd1;
    base[1] = {32'($urandom), 32'hFFFF_FE00}; step_v[1] = 64'd3;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)));
    step(1'b0, 2'b00, 1'b0, 1'b0);
    drain();

    chk("cpu_q_empty", 64'(cpu_q.size()), 64'd0);
    chk("dbg_q_empty", 64'(dbg_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
